// File: rtl/arithm_pkg.sv
// Shared definitions for the arithm_pipe multiply-add pipeline:
// operation encodings, pipeline latency and a small sizing helper.
package arithm_pkg;

  typedef enum logic [1:0] {
    MODE_MAD = 2'b00,  // A*B + C
    MODE_MSB = 2'b01,  // A*B - C
    MODE_ACC = 2'b10,  // acc += A*B
    MODE_RSB = 2'b11   // C - A*B
  } mode_e;

  localparam int ARITHM_LAT = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/arithm_sat.sv
// Combinational signed saturator: clamps an IN_W-bit two's complement value
// into OUT_W bits and flags when clamping happened. Requires IN_W > OUT_W.
module arithm_sat #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val,
  output logic                    o_sat
);

  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-OUT_W:0] w_hi;

  // The value fits iff every bit from the output sign bit upward agrees.
  always_comb begin
    w_hi  = i_val[IN_W-1:OUT_W-1];
    o_sat = !((&w_hi) || (~|w_hi));
    if (o_sat) begin
      o_val = i_val[IN_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      o_val = i_val[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/arithm_pipe.sv
// Three-stage signed multiply-add/accumulate pipeline with saturated output.
// S1 registers operands, S2 registers the scaled product, S3 combines,
// saturates and registers the result. ce stalls every register.
module arithm_pipe
  import arithm_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int FRAC      = 0,
  parameter int ACC_GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic [1:0]              mode,
  input  logic                    acc_clr,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic signed [WIDTH-1:0] C,
  output logic signed [WIDTH-1:0] O,
  output logic                    out_valid,
  output logic                    sat
);

  localparam int PW = 2 * WIDTH;              // full product width
  localparam int SW = 2 * WIDTH + 2;          // non-accumulate sum width
  localparam int AW = 2 * WIDTH + ACC_GUARD;  // accumulator width
  localparam int MW = max_int(SW, AW);        // common width into output saturator

  // Stage 1 registers
  logic                    r_v1;
  mode_e                   r_mode1;
  logic signed [WIDTH-1:0] r_a1, r_b1, r_c1;

  // Stage 2 registers
  logic                    r_v2;
  mode_e                   r_mode2;
  logic signed [PW-1:0]    r_prod2;
  logic signed [WIDTH-1:0] r_c2;

  // Accumulator
  logic signed [AW-1:0]    r_acc;

  // Combinational nets
  logic signed [PW-1:0]    w_prod;
  logic signed [PW-1:0]    w_prod_sh;
  logic signed [SW-1:0]    w_small;
  logic signed [AW-1:0]    w_acc_base;
  logic signed [AW:0]      w_acc_sum;
  logic signed [AW-1:0]    w_acc_new;
  logic                    w_acc_sat;
  logic                    w_is_acc;
  logic signed [MW-1:0]    w_mux;
  logic signed [WIDTH-1:0] w_o;
  logic                    w_o_sat;

  // Stage 1: capture operands, mode and valid.
  // NOTE: reset is synchronous and overrides ce, so a stalled pipe still clears;
  // all state uses non-blocking assignments so stages read last cycle's values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_mode1 <= MODE_MAD;
      r_a1    <= '0;
      r_b1    <= '0;
      r_c1    <= '0;
    end else if (ce) begin
      r_v1    <= in_valid;
      r_mode1 <= mode_e'(mode);
      r_a1    <= A;
      r_b1    <= B;
      r_c1    <= C;
    end
  end

  // Full-width signed product, then arithmetic shift to drop fractional bits.
  assign w_prod    = PW'(r_a1) * PW'(r_b1);
  assign w_prod_sh = w_prod >>> FRAC;

  // Stage 2: register the scaled product alongside C, mode and valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_mode2 <= MODE_MAD;
      r_prod2 <= '0;
      r_c2    <= '0;
    end else if (ce) begin
      r_v2    <= r_v1;
      r_mode2 <= r_mode1;
      r_prod2 <= w_prod_sh;
      r_c2    <= r_c1;
    end
  end

  // Stage 3 combine: two guard bits make add/sub of a product and C wrap-free.
  always_comb begin
    w_small = SW'(r_prod2);
    case (r_mode2)
      MODE_MAD: w_small = SW'(r_prod2) + SW'(r_c2);
      MODE_MSB: w_small = SW'(r_prod2) - SW'(r_c2);
      MODE_RSB: w_small = SW'(r_c2) - SW'(r_prod2);
      default:  w_small = SW'(r_prod2);
    endcase
  end

  // Accumulate path: a coincident clear replaces the old total with zero
  // before the product is added; one extra bit lets the sum clamp, not wrap.
  assign w_is_acc   = (r_mode2 == MODE_ACC);
  assign w_acc_base = acc_clr ? '0 : r_acc;
  assign w_acc_sum  = (AW + 1)'(w_acc_base) + (AW + 1)'(r_prod2);

  arithm_sat #(.IN_W(AW + 1), .OUT_W(AW)) u_sat_acc (
    .i_val (w_acc_sum),
    .o_val (w_acc_new),
    .o_sat (w_acc_sat)
  );

  assign w_mux = w_is_acc ? MW'(w_acc_new) : MW'(w_small);

  arithm_sat #(.IN_W(MW), .OUT_W(WIDTH)) u_sat_out (
    .i_val (w_mux),
    .o_val (w_o),
    .o_sat (w_o_sat)
  );

  // Stage 3 registers: result, flags and accumulator; O/sat hold on bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      O         <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      r_acc     <= '0;
    end else if (ce) begin
      out_valid <= r_v2;
      if (r_v2) begin
        O   <= w_o;
        // A clamped accumulator always lies far outside the output range too.
        sat <= w_o_sat | (w_is_acc & w_acc_sat);
      end
      if (r_v2 && w_is_acc) begin
        r_acc <= w_acc_new;
      end else if (acc_clr) begin
        r_acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arithm_pipe.sv
// Directed bench for arithm_pipe: one instance at FRAC=0 and one at FRAC=4
// share all inputs; expected values are hand-computed constants.
module tb_arithm_pipe;

  localparam int W = 14;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ce;
  logic                in_valid;
  logic [1:0]          mode;
  logic                acc_clr;
  logic signed [W-1:0] A, B, C;
  logic signed [W-1:0] O, O_f;
  logic                out_valid, out_valid_f;
  logic                sat, sat_f;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arithm_pipe #(.WIDTH(W), .FRAC(0), .ACC_GUARD(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
    .acc_clr(acc_clr), .A(A), .B(B), .C(C),
    .O(O), .out_valid(out_valid), .sat(sat)
  );

  arithm_pipe #(.WIDTH(W), .FRAC(4), .ACC_GUARD(4)) dut_f (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
    .acc_clr(acc_clr), .A(A), .B(B), .C(C),
    .O(O_f), .out_valid(out_valid_f), .sat(sat_f)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, clock once, settle 1 time unit past the edge.
  task automatic step(input logic v, input logic [1:0] m, input int a,
                      input int b, input int c, input logic clr,
                      input logic ce_i, input logic rn);
    in_valid = v;
    mode     = m;
    A        = 14'(a);
    B        = 14'(b);
    C        = 14'(c);
    acc_clr  = clr;
    ce       = ce_i;
    rst_n    = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic expect_res(input string tag, input int o, input logic s);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".O"}, O, o);
    check({tag, ".sat"}, sat, s);
  endtask

  task automatic expect_hold(input string tag, input int o, input logic s);
    check({tag, ".valid"}, out_valid, 0);
    check({tag, ".O"}, O, o);
    check({tag, ".sat"}, sat, s);
  endtask

  initial begin
    // Reset
    step(1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b00, 5, 5, 5, 1'b0, 1'b0, 1'b0);
    expect_hold("reset", 0, 1'b0);
    check("reset.valid_f", out_valid_f, 0);

    // Back-to-back samples with mode changing every cycle
    step(1'b1, 2'b00, 500, 3461, 2777, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b00, 3, -4, 10, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b01, 3, -4, 10, 1'b0, 1'b1, 1'b1);
    expect_res("mad_pos_sat", 8191, 1'b1);
    step(1'b1, 2'b11, 3, -4, 10, 1'b0, 1'b1, 1'b1);
    expect_res("mad", -2, 1'b0);
    step(1'b1, 2'b11, 8191, 8191, -8192, 1'b0, 1'b1, 1'b1);
    expect_res("msb", -22, 1'b0);
    idle();
    expect_res("rsb", 22, 1'b0);
    idle();
    expect_res("rsb_neg_sat", -8192, 1'b1);
    idle();
    expect_hold("bubble", -8192, 1'b1);

    // Accumulate sequence, then clear coincident with a mode-10 sample in S3
    step(1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 2'b10, 2, 3, 0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b10, 4, 5, 0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b10, -1, 6, 0, 1'b0, 1'b1, 1'b1);
    expect_res("acc1", 6, 1'b0);
    step(1'b1, 2'b10, 7, 1, 0, 1'b0, 1'b1, 1'b1);
    expect_res("acc2", 26, 1'b0);
    idle();
    expect_res("acc3", 20, 1'b0);
    step(1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    expect_res("acc_clr_add", 7, 1'b0);
    idle();
    expect_hold("acc_bubble", 7, 1'b0);

    // Clear alone: no output, next accumulation starts from zero
    step(1'b0, 2'b00, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    check("clr_no_valid", out_valid, 0);
    step(1'b1, 2'b10, 2, 3, 0, 1'b0, 1'b1, 1'b1);
    idle();
    idle();
    expect_res("acc_after_clr", 6, 1'b0);

    // Stall for 5 cycles with two samples in flight
    step(1'b1, 2'b00, 10, 10, 5, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b01, -20, 3, 4, 1'b0, 1'b1, 1'b1);
    expect_hold("pre_stall", 6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b00, 99, 99, 99, 1'b1, 1'b0, 1'b1);
      expect_hold("stall", 6, 1'b0);
    end
    idle();
    expect_res("stall_x", 105, 1'b0);
    idle();
    expect_res("stall_y", -64, 1'b0);
    idle();
    expect_hold("stall_nodup", -64, 1'b0);

    // Reset with three samples in flight
    step(1'b1, 2'b10, 5, 5, 0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b10, 1, 1, 0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b00, 1, 1, 1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b00, 9, 9, 9, 1'b0, 1'b1, 1'b0);
    expect_hold("midrst", 0, 1'b0);
    idle();
    expect_hold("midrst_c2", 0, 1'b0);
    idle();
    expect_hold("midrst_c3", 0, 1'b0);
    step(1'b1, 2'b10, 2, 3, 0, 1'b0, 1'b1, 1'b1);
    idle();
    check("post_rst_lat", out_valid, 0);
    idle();
    expect_res("post_rst_acc", 6, 1'b0);

    // FRAC=4 instance
    step(1'b1, 2'b00, 64, 32, -100, 1'b0, 1'b1, 1'b1);
    step(1'b1, 2'b00, -8192, -8192, 0, 1'b0, 1'b1, 1'b1);
    idle();
    check("frac.valid", out_valid_f, 1);
    check("frac.O", O_f, 28);
    check("frac.sat", sat_f, 0);
    idle();
    check("frac_sat.O", O_f, 8191);
    check("frac_sat.sat", sat_f, 1);
    expect_res("nofrac_sat", 8191, 1'b1);
    idle();
    check("frac_bubble.valid", out_valid_f, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/arithm_pipe.md
ARITHM_PIPE -- requirements
Module: arithm_pipe

Interface
REQ-001 Parameter WIDTH, default 14, operand and result width in bits (signed two's complement), legal range 4..32.
REQ-002 Parameter FRAC, default 0, number of fractional bits; the product SHALL be arithmetically shifted right by FRAC before summation; legal range 0..WIDTH-1.
REQ-003 Parameter ACC_GUARD, default 4, extra accumulator bits above 2*WIDTH.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset; one clock, reset is synchronous and active-low.
REQ-006 ce  in  1  clock enable; when low, every pipeline and accumulator register SHALL hold its value.
REQ-007 in_valid  in  1  A/B/C/mode sample is valid this cycle (qualified by ce).
REQ-008 mode  in  2  operation: 00 A*B+C, 01 A*B-C, 10 accumulate acc+=A*B, 11 C-A*B.
REQ-009 acc_clr  in  1  clears the accumulator; qualified by ce.
REQ-010 A, B, C  in  WIDTH each  signed operands.
REQ-011 O  out  WIDTH  signed, saturated result.
REQ-012 out_valid  out  1  O holds a new result.
REQ-013 sat  out  1  O was clamped this result; valid only with out_valid.

Function
REQ-014 Pipeline SHALL be 3 stages: S1 registers A, B, C, mode, valid; S2 registers the full 2*WIDTH signed product, shifted by FRAC; S3 performs add/subtract/accumulate, saturates, registers O, sat and out_valid.
REQ-015 Latency SHALL be exactly 3 ce-high cycles from in_valid to out_valid; throughput one result per ce-high cycle.
REQ-016 Intermediate sums SHALL be computed at 2*WIDTH+2 bits (modes 00/01/11) or 2*WIDTH+ACC_GUARD bits (mode 10) with no internal wrap-around.
REQ-017 Saturation SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat=1 iff clamping occurred.
REQ-018 Accumulator SHALL hold the full unsaturated sum; in mode 10, O SHALL be the saturated accumulator value after the update; the accumulator SHALL itself saturate at its own width limits and never wrap.
REQ-019 Accumulator SHALL only change on a valid mode-10 sample reaching S3 or on acc_clr.
REQ-020 acc_clr together with a mode-10 sample reaching S3 in the same cycle: accumulator SHALL become that product (clear, then add).
REQ-021 acc_clr with no mode-10 sample in S3: accumulator SHALL become 0; no out_valid is generated by acc_clr.
REQ-022 Bubbles (in_valid=0) SHALL propagate as out_valid=0; O and sat SHALL hold their last values during bubbles and stalls.
REQ-023 Mode changes between consecutive samples SHALL take effect per sample (mode travels with its data).

Reset
REQ-024 While rst_n=0 at a clock edge, regardless of ce: O=0, out_valid=0, sat=0, accumulator=0, all stage valid bits=0.
REQ-025 Reset mid-operation SHALL discard all in-flight samples; the first input after reset release SHALL emerge 3 ce-high cycles later.

Structure
REQ-026 Shared package arithm_pkg SHALL hold mode encodings (MODE_MAD, MODE_MSB, MODE_ACC, MODE_RSB) and the latency constant ARITHM_LAT=3.
REQ-027 Saturation SHALL be one sub-module arithm_sat (parametrised input width and output width, combinational, outputs value and sat flag), instantiated in S3.

Verification (WIDTH=14, FRAC=0 unless stated)
REQ-028 Mode 00, A=500, B=3461, C=2777 -> 3 cycles later O=8191, sat=1; A=3, B=-4, C=10 -> O=-2, sat=0.
REQ-029 Mode 01 A=3, B=-4, C=10 -> O=-22; mode 11 same operands -> O=22; back-to-back samples with alternating modes -> results in order, one per cycle.
REQ-030 acc_clr, then mode 10 samples (2,3),(4,5),(-1,6) on consecutive cycles -> O=6, 26, 20; acc_clr coincident with (7,1) reaching S3 -> O=7.
REQ-031 ce toggled low for 5 cycles with 2 samples in flight -> O/out_valid frozen, results emerge unchanged after ce returns, no duplicates or drops.
REQ-032 rst_n pulsed low for 1 cycle with 3 samples in flight -> out_valid stays 0 for 3 cycles, O=0, accumulator=0; next sample yields correct result.
REQ-033 FRAC=4, mode 00, A=64, B=32, C=-100 -> O=28; A=-8192, B=-8192, C=0 -> O=8191, sat=1.
